// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and defaults for the asyncmem bus master.
// State encodings are 3-bit so the debug port maps directly onto a scope trigger.
package mem_bus_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_REQ     = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RESP    = 3'd4
    } mbc_state_t;

    localparam int MBC_TIMEOUT = 255;

    // Data is driven only while a write is being set up or requested.
    function automatic logic drives_data(input mbc_state_t s, input logic wr);
        return wr && ((s == ST_SETUP) || (s == ST_REQ));
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_sync_bit.sv
// Multi-flop synchroniser for one asynchronous level; clears to 0 on reset.
module mem_bus_ctrl_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/mem_bus_ctrl.sv
// Bus master bridging a synchronous load/store request port to the asyncmem
// 4-phase handshake (RRq|WRq -> Ack -> release -> Ack low), with per-phase timeout.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int AW          = 16,
    parameter int DW          = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = MBC_TIMEOUT
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          ReqValid,
    output logic          ReqReady,
    input  logic          ReqWrite,
    input  logic [AW-1:0] ReqAddr,
    input  logic [DW-1:0] ReqWData,
    output logic          RspValid,
    output logic [DW-1:0] RspData,
    output logic          RspErr,
    output logic [AW-1:0] Addr,
    output logic          RRq,
    output logic          WRq,
    inout  wire  [DW-1:0] Data,
    input  logic          Ack,
    input  logic          OK,
    output mbc_state_t    dbg_state,
    output logic          dbg_data_oe
);

    // Handshake: a request transfers on the rising Clk edge where ReqValid & ReqReady;
    // the response is a single-cycle RspValid pulse carrying RspData/RspErr.

    localparam int CW = $clog2(TIMEOUT + 1);
    // Abort in the cycle that would be the TIMEOUT-th spent in the phase.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    mbc_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          err_q, err_n;
    logic          wr_q, wr_n;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rsp_data_q;
    logic          rrq_q, wrq_q, oe_q;
    logic          rsp_valid_q, rsp_err_q;
    logic          accept, capture;
    logic          ack_s, ok_s;

    mem_bus_ctrl_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ack (
        .clk   (Clk),
        .rst_n (Rst),
        .d     (Ack),
        .q     (ack_s)
    );

    mem_bus_ctrl_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ok (
        .clk   (Clk),
        .rst_n (Rst),
        .d     (OK),
        .q     (ok_s)
    );

    // A stale Ack from a timed-out transaction must clear before new work starts.
    assign ReqReady = (state == ST_IDLE) && !ack_s;
    assign accept   = ReqValid && ReqReady;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        err_n   = err_q;
        wr_n    = wr_q;
        capture = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (accept) begin
                    state_n = ST_SETUP;
                    wr_n    = ReqWrite;
                    err_n   = 1'b0;
                end
            end
            ST_SETUP: state_n = ST_REQ;
            ST_REQ: begin
                if (ack_s) begin
                    state_n = ST_RELEASE;
                    err_n   = !ok_s;
                    capture = !wr_q;
                    cnt_n   = '0;
                end else if (cnt >= CNT_LAST) begin
                    state_n = ST_RELEASE;
                    err_n   = 1'b1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!ack_s) begin
                    state_n = ST_RESP;
                end else if (cnt >= CNT_LAST) begin
                    state_n = ST_RESP;
                    err_n   = 1'b1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Memory-facing strobes are registered from next-state so they never glitch.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            err_q       <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_data_q  <= '0;
            rrq_q       <= 1'b0;
            wrq_q       <= 1'b0;
            oe_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            err_q <= err_n;
            wr_q  <= wr_n;
            if (accept) begin
                addr_q  <= ReqAddr;
                wdata_q <= ReqWData;
            end
            if (capture) begin
                rsp_data_q <= Data;
            end
            rrq_q       <= (state_n == ST_REQ) && !wr_n;
            wrq_q       <= (state_n == ST_REQ) && wr_n;
            oe_q        <= drives_data(state_n, wr_n);
            rsp_valid_q <= (state_n == ST_RESP);
            rsp_err_q   <= (state_n == ST_RESP) && err_n;
        end
    end

    assign Data        = oe_q ? wdata_q : 'z;
    assign Addr        = addr_q;
    assign RRq         = rrq_q;
    assign WRq         = wrq_q;
    assign RspValid    = rsp_valid_q;
    assign RspData     = rsp_data_q;
    assign RspErr      = rsp_err_q;
    assign dbg_state   = state;
    assign dbg_data_oe = oe_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomised bench for mem_bus_ctrl: asyncmem device model, request driver,
// reference model feeding an expected-response queue, and a per-cycle protocol monitor.
module tb_mem_bus_ctrl;
    import mem_bus_ctrl_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int SS = 2;
    localparam int TO = 15;

    typedef enum int {M_NORMAL, M_ERR, M_NOACK} mode_t;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready, rsp_valid, rsp_err, rrq, wrq, dbg_data_oe;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] addr;
    mbc_state_t    dbg_state;
    wire  [DW-1:0] data_bus;

    logic          mem_ack   = 1'b0;
    logic          mem_ok    = 1'b0;
    logic          ack_force = 1'b0;
    logic          mem_drive = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    wire           ack_line  = mem_ack | ack_force;

    assign data_bus = mem_drive ? mem_rdata : 'z;

    mem_bus_ctrl #(.AW(AW), .DW(DW), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
        .Clk        (clk),
        .Rst        (rst_n),
        .ReqValid   (req_valid),
        .ReqReady   (req_ready),
        .ReqWrite   (req_write),
        .ReqAddr    (req_addr),
        .ReqWData   (req_wdata),
        .RspValid   (rsp_valid),
        .RspData    (rsp_data),
        .RspErr     (rsp_err),
        .Addr       (addr),
        .RRq        (rrq),
        .WRq        (wrq),
        .Data       (data_bus),
        .Ack        (ack_line),
        .OK         (mem_ok),
        .dbg_state  (dbg_state),
        .dbg_data_oe(dbg_data_oe)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- asyncmem device model ----------------
    logic [DW-1:0] mem     [0:65535];
    logic [DW-1:0] ref_mem [0:65535];
    mode_t mem_mode = M_NORMAL;
    mode_t cur_mode = M_NORMAL;
    int    m_phase  = 0;
    int    m_wait   = 0;

    always @(posedge clk) begin
        case (m_phase)
            0: if ((rrq || wrq) && cur_mode != M_NOACK) begin
                m_wait  <= int'($urandom_range(0, 4));
                m_phase <= 1;
            end
            1: if (m_wait > 0) begin
                m_wait <= m_wait - 1;
            end else begin
                if (rrq) begin
                    mem_rdata <= mem[addr];
                    mem_drive <= 1'b1;
                end else if (cur_mode == M_NORMAL) begin
                    mem[addr] <= data_bus;
                end
                mem_ok  <= (cur_mode == M_NORMAL);
                mem_ack <= 1'b1;
                m_phase <= 2;
            end
            2: if (!(rrq || wrq)) begin
                m_wait  <= int'($urandom_range(0, 4));
                m_phase <= 3;
            end
            default: if (m_wait > 0) begin
                m_wait <= m_wait - 1;
            end else begin
                mem_ack   <= 1'b0;
                mem_drive <= 1'b0;
                mem_ok    <= 1'b0;
                m_phase   <= 0;
            end
        endcase
    end

    // ---------------- reference model + monitor ----------------
    logic [DW:0]   exp_q[$];
    logic [DW:0]   e_pop;
    logic          e_err;
    logic [DW-1:0] e_data;
    logic [DW-1:0] last_data = '0;
    logic [AW-1:0] cur_addr  = '0;
    logic [DW-1:0] cur_wdata = '0;
    logic          cur_write = 1'b0;
    logic          prev_req = 1'b0, prev_wrq = 1'b0, prev_rv = 1'b0;
    int cyc = 0, acc_cyc = -100, rrq_run = 0, last_run = -1, n_rsp = 0;
    int v_oe_read = 0, v_both = 0, v_wdata = 0, v_addr = 0, v_rv_wide = 0;
    int v_lat = 0, v_release = 0, v_setup = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_req = 1'b0;
            prev_wrq = 1'b0;
            prev_rv  = 1'b0;
            rrq_run  = 0;
        end else begin
            if (req_valid && req_ready) begin
                // Expected outcome follows from memory behaviour alone.
                e_err = (mem_mode != M_NORMAL);
                if (mem_mode != M_NOACK && !req_write) e_data = ref_mem[req_addr];
                else e_data = last_data;
                if (req_write && mem_mode == M_NORMAL) ref_mem[req_addr] = req_wdata;
                last_data = e_data;
                exp_q.push_back({e_err, e_data});
                cur_addr  = req_addr;
                cur_wdata = req_wdata;
                cur_write = req_write;
                cur_mode  = mem_mode;
                acc_cyc   = cyc;
            end
            if (cyc == acc_cyc + 1 && cur_write && (!dbg_data_oe || data_bus !== cur_wdata)) v_setup++;
            if ((rrq || wrq) && !prev_req && (cyc - acc_cyc != 2)) v_lat++;
            if (rrq || wrq) rrq_run++;
            else if (prev_req) begin
                last_run = rrq_run;
                rrq_run  = 0;
            end
            if (dbg_data_oe && rrq) v_oe_read++;
            if (rrq && wrq) v_both++;
            if (wrq && (!dbg_data_oe || data_bus !== cur_wdata)) v_wdata++;
            if ((rrq || wrq) && addr !== cur_addr) v_addr++;
            if (prev_wrq && !wrq && dbg_data_oe) v_release++;
            if (rsp_valid) begin
                n_rsp++;
                if (prev_rv) v_rv_wide++;
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e_pop = exp_q.pop_front();
                    check("rsp_data", 32'(rsp_data), 32'(e_pop[DW-1:0]));
                    check("rsp_err", 32'(rsp_err), 32'(e_pop[DW]));
                end
            end
            prev_req = rrq || wrq;
            prev_wrq = wrq;
            prev_rv  = rsp_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input mode_t mode);
        bit ok;
        ok        = 1'b0;
        mem_mode  = mode;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(input int target);
        for (int i = 0; i < 300 && n_rsp < target; i++) @(posedge clk);
        #1;
        check("rsp_arrived", 32'(n_rsp), 32'(target));
    endtask

    task automatic single(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input mode_t mode);
        int target;
        target = n_rsp + 1;
        issue(wr, a, d, mode);
        req_valid = 1'b0;
        wait_rsp(target);
    endtask

    // ---------------- main sequence ----------------
    int base;
    mode_t rmode;
    int r;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'(i * 37) ^ 16'h5A5A;
            ref_mem[i] = mem[i];
        end
        mem[16'hFFF0]     = 16'hBEEF;
        ref_mem[16'hFFF0] = 16'hBEEF;

        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rrq", 32'(rrq), 32'd0);
        check("rst_wrq", 32'(wrq), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_data_oe", 32'(dbg_data_oe), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Directed read, write with read-back, error status
        single(1'b0, 16'hFFF0, 16'h0000, M_NORMAL);
        check("read_beef", 32'(rsp_data), 32'h0000BEEF);
        single(1'b1, 16'h0040, 16'h1234, M_NORMAL);
        check("mem_0040", 32'(mem[16'h0040]), 32'h00001234);
        single(1'b0, 16'h0040, 16'h0000, M_NORMAL);
        check("readback_0040", 32'(rsp_data), 32'h00001234);
        single(1'b0, 16'h0100, 16'h0000, M_ERR);
        single(1'b1, 16'h0101, 16'hAAAA, M_ERR);
        single(1'b0, 16'h0101, 16'h0000, M_NORMAL);

        // Timeout with no Ack, then a late Ack pulse holds off new work
        single(1'b0, 16'h0200, 16'h0000, M_NOACK);
        check("timeout_req_cycles", 32'(last_run), 32'(TO));
        ack_force = 1'b1;
        repeat (5) @(negedge clk);
        check("late_ack_blocks", 32'(req_ready), 32'd0);
        ack_force = 1'b0;
        repeat (4) @(negedge clk);
        check("late_ack_cleared", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Reset in the middle of a write request
        issue(1'b1, 16'h0300, 16'hCAFE, M_NOACK);
        req_valid = 1'b0;
        for (int i = 0; i < 10 && !wrq; i++) @(negedge clk);
        check("midop_wrq_seen", 32'(wrq), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midop_wrq_drop", 32'(wrq), 32'd0);
        check("midop_rrq_drop", 32'(rrq), 32'd0);
        check("midop_data_z", 32'(dbg_data_oe), 32'd0);
        base = n_rsp;
        exp_q.delete();
        last_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midop_no_rsp", 32'(n_rsp), 32'(base));
        check("midop_no_write", 32'(mem[16'h0300]), 32'(ref_mem[16'h0300]));
        single(1'b0, 16'hFFF0, 16'h0000, M_NORMAL);
        check("post_reset_read", 32'(rsp_data), 32'h0000BEEF);

        // Back-to-back reads with ReqValid held high
        base = n_rsp;
        for (int k = 0; k < 4; k++) issue(1'b0, 16'(16'h0010 + k), 16'h0000, M_NORMAL);
        req_valid = 1'b0;
        wait_rsp(base + 4);
        repeat (20) @(posedge clk);
        #1;
        check("b2b_count", 32'(n_rsp - base), 32'd4);

        // Randomised mix
        for (int k = 0; k < 60; k++) begin
            r = int'($urandom_range(0, 9));
            rmode = (r < 7) ? M_NORMAL : (r < 9) ? M_ERR : M_NOACK;
            issue(1'($urandom_range(0, 1)), 16'(16'h0020 + $urandom_range(0, 7)),
                  16'($urandom), rmode);
            if ($urandom_range(0, 1) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        req_valid = 1'b0;
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        check("queue_drain", 32'(exp_q.size()), 32'd0);

        check("proto_data_in_read", 32'(v_oe_read), 32'd0);
        check("proto_rrq_and_wrq", 32'(v_both), 32'd0);
        check("proto_wdata_on_bus", 32'(v_wdata), 32'd0);
        check("proto_addr_stable", 32'(v_addr), 32'd0);
        check("proto_rsp_one_cycle", 32'(v_rv_wide), 32'd0);
        check("proto_req_latency", 32'(v_lat), 32'd0);
        check("proto_data_release", 32'(v_release), 32'd0);
        check("proto_data_in_setup", 32'(v_setup), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
